// File: rtl/fifo_ser_pkg.sv
// Shared widths and FSM state encoding for the FIFO word serializer.
package fifo_ser_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int WCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } ser_state_t;

  // Symbol index width; a one-symbol word still gets a 1-bit index.
  function automatic int idx_width(input int nsym);
    return (nsym > 1) ? $clog2(nsym) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_byte_shifter.sv
// Holds one FIFO word and presents the symbol selected by a running index.
// Latency: load/shift take effect on the next edge; dout is a pure mux of registered state.
module byte_shifter
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              last
);

  localparam int NSYM  = DATA_W / BYTE_W;
  localparam int IDX_W = idx_width(NSYM);

  logic [DATA_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= din;
      idx  <= '0;
    end else if (shift) begin
      idx  <= idx + 1'b1;
    end
  end

  assign last = (idx == IDX_W'(NSYM - 1));

  // The index never passes NSYM-1: the FSM does not shift on the last symbol.
  always_comb begin
    if (MSB_FIRST) dout = sreg[(NSYM - 1 - int'(idx)) * BYTE_W +: BYTE_W];
    else           dout = sreg[int'(idx) * BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a show-ahead-less FIFO and streams them out as BYTE_W symbols.
// Latency: 3 cycles empty-fall to first byte_valid; byte_ready=0 or en=0 stalls the current symbol.
// Optional FIFO_SER_PARITY_EN adds byte_par, the XOR of byte_out.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                fifo_rd,
  output logic [BYTE_W-1:0]   byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                busy,
  output logic [WCNT_W-1:0]   word_count
`ifdef FIFO_SER_PARITY_EN
  ,
  output logic                byte_par
`endif
);

  ser_state_t state, state_nxt;
  logic       sh_load, sh_shift, sh_last, word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // en=0 freezes everything, so all strobes stay in their defaults.
  always_comb begin
    state_nxt  = state;
    fifo_rd    = 1'b0;
    byte_valid = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    word_done  = 1'b0;
    if (en) begin
      case (state)
        IDLE: if (!fifo_empty) state_nxt = REQ;
        REQ: begin
          fifo_rd   = 1'b1;
          state_nxt = LOAD;
        end
        LOAD: begin
          sh_load   = 1'b1;
          state_nxt = SEND;
        end
        SEND: begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            if (sh_last) begin
              word_done = 1'b1;
              state_nxt = fifo_empty ? IDLE : REQ;
            end else begin
              sh_shift = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         word_count <= '0;
    else if (word_done) word_count <= word_count + 1'b1;
  end

  byte_shifter #(
    .DATA_W    (DATA_W),
    .BYTE_W    (BYTE_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (fifo_data),
    .dout  (byte_out),
    .last  (sh_last)
  );

`ifdef FIFO_SER_PARITY_EN
  // byte_out comes straight off the shift register, so parity is aligned with it.
  assign byte_par = ^byte_out;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: vector table of words plus hand sequences for stall, enable, reset and LSB-first order.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n, en, byte_ready;
  logic        fifo_empty, fifo_rd, byte_valid, busy;
  logic [31:0] fifo_data = '0;
  logic [7:0]  byte_out;
  logic [15:0] word_count;

  logic        l_empty, l_rd, l_valid, l_busy;
  logic        l_ready = 1'b1;
  logic [31:0] l_data;
  logic [7:0]  l_byte;
  logic [15:0] l_wc;
`ifdef FIFO_SER_PARITY_EN
  logic        byte_par, l_par;
`endif

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .word_count(word_count)
`ifdef FIFO_SER_PARITY_EN
    , .byte_par(byte_par)
`endif
  );

  fifo_word_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(l_empty), .fifo_data(l_data),
    .fifo_rd(l_rd), .byte_out(l_byte), .byte_valid(l_valid), .byte_ready(l_ready),
    .busy(l_busy), .word_count(l_wc)
`ifdef FIFO_SER_PARITY_EN
    , .byte_par(l_par)
`endif
  );

  // Upstream FIFO model: data appears the cycle after the read strobe is sampled.
  logic [31:0] mem [0:63];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Accepted-symbol log, sampled mid-cycle while inputs are stable.
  int          cyc = 0;
  int          cap_n = 0;
  int          rd_n = 0;
  logic [7:0]  cap_dat [0:255];
  int          cap_cyc [0:255];
  logic        cap_par [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && byte_valid && byte_ready) begin
      cap_dat[cap_n] <= byte_out;
      cap_cyc[cap_n] <= cyc;
`ifdef FIFO_SER_PARITY_EN
      cap_par[cap_n] <= byte_par;
`else
      cap_par[cap_n] <= 1'b0;
`endif
      cap_n <= cap_n + 1;
    end
    if (rst_n && fifo_rd) rd_n <= rd_n + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, output int pc);
    @(posedge clk); #1;
    mem[wr_cnt] = w;
    wr_cnt++;
    pc = cyc;
  endtask

  task automatic wait_caps(input int n, input int budget, input string nm);
    int k = 0;
    while (cap_n < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(nm, 32'(cap_n >= n), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    @(negedge clk); #1;
    while (!byte_valid && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check(nm, 32'(byte_valid), 32'd1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b [4];
  } vec_t;

  vec_t vec [5];
  int   vbase [5];

  initial begin
    int pc, base, rb, exp_wc;
    logic [7:0] e;

    vec[0] = '{32'h11223344, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vec[1] = '{32'h00FF8001, '{8'h00, 8'hFF, 8'h80, 8'h01}};
    vec[2] = '{32'h07030000, '{8'h07, 8'h03, 8'h00, 8'h00}};
    vec[3] = '{32'hA55AC33C, '{8'hA5, 8'h5A, 8'hC3, 8'h3C}};
    vec[4] = '{32'hFEDCBA98, '{8'hFE, 8'hDC, 8'hBA, 8'h98}};

    rst_n = 1'b0; en = 1'b1; byte_ready = 1'b1;
    l_empty = 1'b1; l_data = '0;
    exp_wc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table, ready held high.
    for (int i = 0; i < 5; i++) begin
      base = cap_n;
      rb = rd_n;
      vbase[i] = base;
      push(vec[i].word, pc);
      wait_caps(base + 4, 20, $sformatf("vec%0d_timeout", i));
      for (int j = 0; j < 4; j++)
        check($sformatf("vec%0d_byte%0d", i, j), 32'(cap_dat[base + j]), 32'(vec[i].b[j]));
      check($sformatf("vec%0d_latency", i), 32'(cap_cyc[base] - pc), 32'd3);
      check($sformatf("vec%0d_back2back", i), 32'(cap_cyc[base + 3] - cap_cyc[base]), 32'd3);
      @(negedge clk); #1;
      exp_wc++;
      check($sformatf("vec%0d_word_count", i), 32'(word_count), 32'(exp_wc));
      check($sformatf("vec%0d_reads", i), 32'(rd_n - rb), 32'd1);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end
`ifdef FIFO_SER_PARITY_EN
    check("par_07", 32'(cap_par[vbase[2]]), 32'd1);
    check("par_03", 32'(cap_par[vbase[2] + 1]), 32'd0);
`endif

    // Nine queued words 0..8.
    base = cap_n;
    rb = rd_n;
    @(posedge clk); #1;
    for (int w = 0; w < 9; w++) begin
      mem[wr_cnt] = 32'(w);
      wr_cnt++;
    end
    wait_caps(base + 36, 200, "burst_timeout");
    for (int k = 0; k < 36; k++) begin
      e = ((k % 4) == 3) ? 8'(k / 4) : 8'h00;
      check($sformatf("burst_byte%0d", k), 32'(cap_dat[base + k]), 32'(e));
    end
    check("burst_gap", 32'(cap_cyc[base + 4] - cap_cyc[base + 3]), 32'd3);
    repeat (3) begin @(negedge clk); #1; end
    exp_wc += 9;
    check("burst_reads", 32'(rd_n - rb), 32'd9);
    check("burst_word_count", 32'(word_count), 32'(exp_wc));
    check("burst_idle", 32'(busy), 32'd0);

    // Backpressure: ready 1,0,0,1 across the word.
    base = cap_n;
    push(32'hDEADBEEF, pc);
    wait_valid("bp_valid_timeout");
    @(posedge clk); #1; byte_ready = 1'b0;
    @(negedge clk); #1;
    check("bp_hold1_byte", 32'(byte_out), 32'hAD);
    check("bp_hold1_valid", 32'(byte_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("bp_hold2_byte", 32'(byte_out), 32'hAD);
    @(posedge clk); #1; byte_ready = 1'b1;
    wait_caps(base + 4, 20, "bp_timeout");
    check("bp_b0", 32'(cap_dat[base]), 32'hDE);
    check("bp_b1", 32'(cap_dat[base + 1]), 32'hAD);
    check("bp_b2", 32'(cap_dat[base + 2]), 32'hBE);
    check("bp_b3", 32'(cap_dat[base + 3]), 32'hEF);
    repeat (3) begin @(negedge clk); #1; end
    exp_wc++;
    check("bp_count", 32'(cap_n - base), 32'd4);
    check("bp_word_count", 32'(word_count), 32'(exp_wc));

    // Enable dropped mid-word.
    base = cap_n;
    push(32'h55667788, pc);
    wait_valid("en_valid_timeout");
    @(posedge clk); #1; en = 1'b0;
    @(negedge clk); #1;
    check("en_off_valid", 32'(byte_valid), 32'd0);
    check("en_off_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("en_off_held", 32'(cap_n - base), 32'd1);
    @(posedge clk); #1; en = 1'b1;
    wait_caps(base + 4, 20, "en_timeout");
    check("en_b0", 32'(cap_dat[base]), 32'h55);
    check("en_b1", 32'(cap_dat[base + 1]), 32'h66);
    check("en_b2", 32'(cap_dat[base + 2]), 32'h77);
    check("en_b3", 32'(cap_dat[base + 3]), 32'h88);
    @(negedge clk); #1;
    exp_wc++;
    check("en_word_count", 32'(word_count), 32'(exp_wc));

    // LSB-first instance, FIFO handshake driven by hand.
    begin
      int k = 0;
      @(posedge clk); #1; l_empty = 1'b0;
      @(negedge clk); #1;
      while (!l_rd && k < 10) begin @(negedge clk); #1; k++; end
      check("lsb_rd_timeout", 32'(l_rd), 32'd1);
      @(posedge clk); #1; l_data = 32'hA1B2C3D4; l_empty = 1'b1;
      k = 0;
      @(negedge clk); #1;
      while (!l_valid && k < 10) begin @(negedge clk); #1; k++; end
      check("lsb_valid_timeout", 32'(l_valid), 32'd1);
      check("lsb_b0", 32'(l_byte), 32'hD4);
      @(negedge clk); #1;
      check("lsb_b1", 32'(l_byte), 32'hC3);
      @(negedge clk); #1;
      check("lsb_b2", 32'(l_byte), 32'hB2);
      @(negedge clk); #1;
      check("lsb_b3", 32'(l_byte), 32'hA1);
      @(negedge clk); #1;
      check("lsb_word_count", 32'(l_wc), 32'd1);
      check("lsb_idle", 32'(l_busy), 32'd0);
    end

    // Reset after the second byte of a word.
    base = cap_n;
    push(32'h01020304, pc);
    wait_caps(base + 2, 20, "rst_mid_timeout");
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(byte_valid), 32'd0);
    check("rst_mid_word_count", 32'(word_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_byte_out", 32'(byte_out), 32'd0);
    check("rst_mid_bytes", 32'(cap_n - base), 32'd2);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    base = cap_n;
    push(32'hCAFEF00D, pc);
    wait_caps(base + 4, 20, "post_rst_timeout");
    check("post_rst_b0", 32'(cap_dat[base]), 32'hCA);
    check("post_rst_b1", 32'(cap_dat[base + 1]), 32'hFE);
    check("post_rst_b2", 32'(cap_dat[base + 2]), 32'hF0);
    check("post_rst_b3", 32'(cap_dat[base + 3]), 32'h0D);
    @(negedge clk); #1;
    check("post_rst_word_count", 32'(word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
